// File: rtl/ahb_result_reader.sv
// AHB-Lite slave that hands SNN result words to the CPU.
// It locks the result buffer, raises an interrupt, and serves DATA reads through an auto-incrementing pointer.
module ahb_result_reader #(
  parameter logic [31:0] BASE_ADDR = 32'h4002_1000,
  parameter int          ADDR_W    = 11
) (
  input  logic              hclk,
  input  logic              hrst_b,
  input  logic              hsel,
  input  logic [31:0]       haddr,
  input  logic [1:0]        htrans,
  input  logic              hwrite,
  input  logic [31:0]       hwdata,
  input  logic              hready_in,
  output logic              hready,
  output logic [31:0]       hrdata,
  output logic [1:0]        hresp,
  input  logic              res_done,
  input  logic [ADDR_W:0]   res_len,
  output logic              buf_rd_en,
  output logic [ADDR_W-1:0] buf_rd_addr,
  input  logic [31:0]       buf_rd_data,
  output logic              buf_lock,
  output logic              intr
);

  typedef enum logic [1:0] {IDLE, RD_WAIT, RD_OUT} state_t;

  localparam logic [1:0]        OFF_PTR    = 2'd0;
  localparam logic [1:0]        OFF_DATA   = 2'd1;
  localparam logic [1:0]        OFF_COUNT  = 2'd2;
  localparam logic [1:0]        OFF_STATUS = 2'd3;
  localparam logic [ADDR_W-1:0] PTR_ONE    = 1;

  state_t            state_q, state_d;
  logic              dp_valid_q, dp_write_q, dp_mapped_q;
  logic [1:0]        dp_off_q;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              valid_q, valid_d, udf_q, udf_d, ovr_q, ovr_d, ie_q, ie_d;
  logic              intr_q;
  logic [31:0]       rd_data_q;

  logic              accept, addr_mapped, wr_en, wr_ptr, wr_status;
  logic              data_rd, rd_ok, valid_eff;
  logic [1:0]        addr_off;
  logic [ADDR_W-1:0] ptr_eff;

  assign hready      = (state_q != RD_WAIT);
  assign hresp       = 2'b00;
  assign accept      = hsel & htrans[1] & hready_in & hready;
  assign addr_mapped = (haddr[31:4] == BASE_ADDR[31:4]);
  assign addr_off    = haddr[3:2];

  assign wr_en     = dp_valid_q & dp_write_q & dp_mapped_q & hready;
  assign wr_ptr    = wr_en & (dp_off_q == OFF_PTR);
  assign wr_status = wr_en & (dp_off_q == OFF_STATUS);

  // A write completing in this cycle must be visible to a DATA read whose address phase overlaps it.
  assign ptr_eff   = wr_ptr ? hwdata[ADDR_W-1:0] : ptr_q;
  assign valid_eff = valid_q & ~(wr_status & hwdata[0]);

  assign data_rd     = accept & ~hwrite & addr_mapped & (addr_off == OFF_DATA);
  assign rd_ok       = valid_eff & ({1'b0, ptr_eff} < count_q);
  assign buf_rd_en   = data_rd & rd_ok;
  assign buf_rd_addr = ptr_eff;
  assign buf_lock    = valid_q;
  assign intr        = intr_q;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_d = state_q;
    case (state_q)
      RD_WAIT: state_d = RD_OUT;
      default: state_d = (data_rd && rd_ok) ? RD_WAIT : IDLE;
    endcase
  end

  always_comb begin
    ptr_d   = ptr_q;
    count_d = count_q;
    valid_d = valid_q;
    udf_d   = udf_q;
    ovr_d   = ovr_q;
    ie_d    = ie_q;
    if (wr_ptr) ptr_d = hwdata[ADDR_W-1:0];
    if (wr_status) begin
      valid_d = valid_q & ~hwdata[0];
      udf_d   = udf_q & ~hwdata[1];
      ovr_d   = ovr_q & ~hwdata[2];
      ie_d    = hwdata[3];
    end
    if (state_q == RD_WAIT) ptr_d = ptr_q + PTR_ONE;
    if (data_rd && !rd_ok) udf_d = 1'b1;
    // The STATUS clear is applied before res_done is judged, so a simultaneous clear lets a new result in.
    if (res_done) begin
      if (valid_d) begin
        ovr_d = 1'b1;
      end else begin
        count_d = res_len;
        ptr_d   = '0;
        valid_d = 1'b1;
      end
    end
  end

  always_comb begin
    hrdata = '0;
    if (dp_valid_q && !dp_write_q && dp_mapped_q) begin
      case (dp_off_q)
        OFF_PTR:   hrdata = 32'(ptr_q);
        OFF_DATA:  hrdata = (state_q == RD_OUT) ? rd_data_q : '0;
        OFF_COUNT: hrdata = 32'(count_q);
        default:   hrdata = {28'b0, ie_q, ovr_q, udf_q, valid_q};
      endcase
    end
  end

  always_ff @(posedge hclk or negedge hrst_b) begin
    if (!hrst_b) begin
      state_q     <= IDLE;
      dp_valid_q  <= 1'b0;
      dp_write_q  <= 1'b0;
      dp_mapped_q <= 1'b0;
      dp_off_q    <= '0;
      ptr_q       <= '0;
      count_q     <= '0;
      valid_q     <= 1'b0;
      udf_q       <= 1'b0;
      ovr_q       <= 1'b0;
      ie_q        <= 1'b0;
      intr_q      <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
      state_q <= state_d;
      ptr_q   <= ptr_d;
      count_q <= count_d;
      valid_q <= valid_d;
      udf_q   <= udf_d;
      ovr_q   <= ovr_d;
      ie_q    <= ie_d;
      intr_q  <= valid_d & ie_d;
      if (hready) begin
        dp_valid_q  <= accept;
        dp_write_q  <= hwrite;
        dp_mapped_q <= addr_mapped;
        dp_off_q    <= addr_off;
      end
      if (state_q == RD_WAIT) rd_data_q <= buf_rd_data;
    end
  end

endmodule
